// File: rtl/memwriter.sv
// rtl/memwriter.sv - 16-deep fill-once memory writer with registered read port
module memwriter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             valid,
   output logic             ready,
   input  logic [3:0]       addr,
   output logic [WIDTH-1:0] dout,
   output logic [4:0]       count,
   output logic             full,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       wptr_q, wptr_d;
   logic [4:0]       count_q, count_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             wr_en;

   // Storage is deliberately left out of reset; only a completed fill makes it meaningful.
   logic [WIDTH-1:0] mem_q [16];

   // Next-state logic: start always wins over a beat, and ready/full depend on state alone.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      ready   = 1'b0;
      full    = 1'b0;
      dout_d  = mem_q[addr];

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               wptr_d  = 4'd0;
               count_d = 5'd0;
            end
         end

         FILL: begin
            ready = 1'b1;
            if (start) begin
               wptr_d  = 4'd0;
               count_d = 5'd0;
            end else if (valid) begin
               wr_en   = 1'b1;
               wptr_d  = wptr_q + 4'd1;
               count_d = count_q + 5'd1;
               // The last slot completes the fill; done rises together with full.
               if (wptr_q == 4'd15) begin
                  state_d = FULL;
                  done_d  = 1'b1;
               end
            end
         end

         FULL: begin
            full = 1'b1;
            if (start) begin
               state_d = FILL;
               wptr_d  = 4'd0;
               count_d = 5'd0;
            end
         end

         default: begin
            state_d = IDLE;
            wptr_d  = 4'd0;
            count_d = 5'd0;
         end
      endcase
   end

   // Control and read-data registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wptr_q  <= 4'd0;
         count_q <= 5'd0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
      end
   end

   // Memory write; a beat coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem_q[wptr_q] <= din;
      end
   end

   assign dout  = dout_q;
   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_memwriter.sv
// tb/tb_memwriter.sv - scoreboard bench for memwriter
module tb_memwriter;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] din;
   logic             valid;
   logic             ready;
   logic [3:0]       addr;
   logic [WIDTH-1:0] dout;
   logic [4:0]       count;
   logic             full;
   logic             done;

   memwriter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .din   (din),
      .valid (valid),
      .ready (ready),
      .addr  (addr),
      .dout  (dout),
      .count (count),
      .full  (full),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             chk;
      logic [WIDTH-1:0] val;
   } exp_t;

   exp_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: 0 = IDLE, 1 = FILL, 2 = FULL
   int               m_state = 0;
   logic [3:0]       m_wptr  = 4'd0;
   logic [4:0]       m_count = 5'd0;
   logic             m_done  = 1'b0;
   logic [WIDTH-1:0] m_mem   [16];
   logic             m_known [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, predict, advance past the edge, compare everything.
   task automatic cycle(input logic rst, input logic st, input logic v,
                        input logic [WIDTH-1:0] d, input logic [3:0] a);
      exp_t e;
      reset = rst;
      start = st;
      valid = v;
      din   = d;
      addr  = a;
      #1;
      check("ready", {31'd0, ready}, {31'd0, (m_state == 1)});

      e.chk = rst ? 1'b1 : m_known[a];
      e.val = rst ? '0 : m_mem[a];
      sb_q.push_back(e);

      if (rst) begin
         m_state = 0; m_wptr = 4'd0; m_count = 5'd0; m_done = 1'b0;
      end else if (st) begin
         m_state = 1; m_wptr = 4'd0; m_count = 5'd0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_state == 1 && v) begin
            m_mem[m_wptr]   = d;
            m_known[m_wptr] = 1'b1;
            m_count         = m_count + 5'd1;
            if (m_wptr == 4'd15) begin
               m_state = 2;
               m_done  = 1'b1;
            end
            m_wptr = m_wptr + 4'd1;
         end
      end

      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         if (e.chk) check("dout", {28'd0, dout}, {28'd0, e.val});
      end
      check("count", {27'd0, count}, {27'd0, m_count});
      check("full", {31'd0, full}, {31'd0, (m_state == 2)});
      check("done", {31'd0, done}, {31'd0, m_done});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_mem[i]   = '0;
         m_known[i] = 1'b0;
      end
      reset = 1'b1; start = 1'b0; valid = 1'b0; din = '0; addr = 4'd0;
      @(posedge clk);
      #1;

      // Reset state
      cycle(1, 0, 0, 0, 0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_dout", {28'd0, dout}, 32'd0);

      // Full fill of 0..15, reads on the fly and afterwards
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 1, 4'(i), 4'(15 - i));
         check("s1_count_step", {27'd0, count}, 32'(i + 1));
      end
      check("s1_full", {31'd0, full}, 32'd1);
      check("s1_done", {31'd0, done}, 32'd1);
      cycle(0, 0, 0, 0, 0);
      check("s1_done_pulse", {31'd0, done}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 0, 0, 4'(i));
         check("s1_read", {28'd0, dout}, 32'(i));
      end

      // FULL ignores valid
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 1, 4'd15, 4'd2);
         check("full_ready", {31'd0, ready}, 32'd0);
         check("full_count", {27'd0, count}, 32'd16);
         check("full_done", {31'd0, done}, 32'd0);
         check("full_mem2", {28'd0, dout}, 32'd2);
      end

      // Toggling valid: only valid beats land, contiguously
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         cycle(0, 0, (i % 2 == 0), 4'((i / 2) ^ 5), 4'(i % 16));
      end
      check("tog_full", {31'd0, full}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 0, 0, 4'(i));
         check("tog_read", {28'd0, dout}, 32'(i ^ 5));
      end

      // Restart after 5 beats with a coincident beat of 9
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 4'(10 + i), 4'd0);
      check("rs_count5", {27'd0, count}, 32'd5);
      cycle(0, 1, 1, 4'd9, 4'd0);
      check("rs_count0", {27'd0, count}, 32'd0);
      cycle(0, 0, 0, 0, 4'd0);
      check("rs_mem0_kept", {28'd0, dout}, 32'd10);
      cycle(0, 0, 1, 4'd5, 4'd0);
      check("rs_old_at_write", {28'd0, dout}, 32'd10);
      cycle(0, 0, 0, 0, 4'd0);
      check("rs_new_at_addr0", {28'd0, dout}, 32'd5);

      // Read-during-write to address 3 returns old data first
      cycle(0, 0, 1, 4'd1, 4'd0);
      cycle(0, 0, 1, 4'd2, 4'd0);
      cycle(0, 0, 1, 4'd7, 4'd3);
      check("rdw_old", {28'd0, dout}, 32'd13);
      cycle(0, 0, 0, 0, 4'd3);
      check("rdw_new", {28'd0, dout}, 32'd7);

      // Reset mid-fill after 8 beats, then a clean refill
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 4'(i + 3), 4'(i));
      cycle(1, 0, 1, 4'd6, 4'd4);
      check("mr_ready", {31'd0, ready}, 32'd0);
      check("mr_count", {27'd0, count}, 32'd0);
      check("mr_full", {31'd0, full}, 32'd0);
      check("mr_dout", {28'd0, dout}, 32'd0);
      cycle(0, 1, 1, 4'd1, 4'd0);
      for (int i = 0; i < 16; i++) cycle(0, 0, 1, 4'(15 - i), 4'(i));
      check("mr_full2", {31'd0, full}, 32'd1);
      check("mr_done2", {31'd0, done}, 32'd1);
      cycle(0, 0, 0, 0, 4'd9);
      check("mr_read9", {28'd0, dout}, 32'd6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memwriter.md
MEMWRITER -- requirements
Module: memwriter

Interface
REQ-001 Parameter: WIDTH, 4, data word width in bits; depth is fixed at 16 words with a 4-bit address.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start  input  1  begin or restart a fill sequence at address 0.
REQ-005 Port: din  input  WIDTH  write data from the producer.
REQ-006 Port: valid  input  1  producer asserts that din holds a word.
REQ-007 Port: ready  output  1  block accepts a word this cycle.
REQ-008 Port: addr  input  4  read address from the reader.
REQ-009 Port: dout  output  WIDTH  registered read data.
REQ-010 Port: count  output  5  number of words written in the current fill, 0..16.
REQ-011 Port: full  output  1  all 16 words of the current fill have been written.
REQ-012 Port: done  output  1  one-cycle pulse when the fill completes.

Function
REQ-013 Storage: 16 x WIDTH memory array; contents are not initialised by reset.
REQ-014 FSM states: IDLE, FILL, FULL.
REQ-015 IDLE: ready=0, full=0; start=1 moves to FILL with the write pointer (wptr) and count cleared.
REQ-016 FILL: ready=1 combinationally; valid&ready at an edge writes din to mem[wptr], then increments wptr and count by 1.
REQ-017 FILL: valid=0 holds state, wptr and count unchanged; no write occurs.
REQ-018 FILL: an accepted write with wptr=15 moves to FULL with count=16; wptr wraps to 0.
REQ-019 FULL: ready=0, full=1; valid is ignored and memory is unchanged.
REQ-020 done=1 for exactly the one cycle after entry to FULL (the cycle in which full first reads 1), then 0.
REQ-021 start in FILL or FULL: next state FILL, wptr=0, count=0, full=0.
REQ-022 start has priority over valid: a beat presented in the same cycle as start is not written and is not counted.
REQ-023 start in IDLE with valid=1: only the transition occurs; no write takes place that cycle.
REQ-024 Read port: dout <= mem[addr] every edge, in every state; latency is 1 cycle.
REQ-025 Read of the address being written in the same edge returns the old (pre-write) contents; the new value appears one edge later.
REQ-026 count is the registered value; it equals the number of accepted beats since the last start, saturating at 16.
REQ-027 ready depends only on the state; it has no combinational dependence on valid.

Reset
REQ-028 reset=1 at an edge forces: state IDLE, wptr=0, count=0, ready=0, full=0, done=0, dout=0.
REQ-029 reset has priority over start and valid in the same cycle; no memory write occurs during reset.
REQ-030 Reset mid-FILL abandons the fill; words already written remain in memory but are not valid until a new fill completes.

Verification
REQ-031 Scenario: reset, start, 16 consecutive beats din=0..15 with valid=1 -> ready high for 16 cycles; count steps 1..16; full=1 and done a single-cycle pulse after the 16th beat; reading addr=0..15 returns 0..15 with 1-cycle latency.
REQ-032 Scenario: valid toggling 1,0,1,0 during FILL -> only beats with valid=1 are written; count increments only on those edges; no gaps appear in the addresses written.
REQ-033 Scenario: after 5 beats, pulse start together with valid=1, din=9 -> count=0, mem[0] is not overwritten by 9, and the next beat is written to addr 0.
REQ-034 Scenario: in FULL, drive valid=1, din=15 for 4 cycles -> ready=0, memory unchanged, count=16, done stays 0.
REQ-035 Scenario: assert reset after 8 beats -> next cycle ready=0, count=0, full=0, dout=0; a following start plus 16 beats completes normally.
REQ-036 Scenario: write 7 to addr 3 while addr=3 -> dout shows the old value at the next edge and 7 one edge later.
